// File: rtl/div_result_buffer.sv
// div_result_buffer: elastic FIFO behind the divider with sticky overflow.
// Optional drop counter enabled by DIV_RESULT_BUF_DROP_CNT_EN.
module div_result_buffer #(
  parameter int N     = 5,
  parameter int M     = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       result_ready,
  input  logic [N-1:0]               merchant,
  input  logic [M-1:0]               remainder,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N-1:0]               out_merchant,
  output logic [M-1:0]               out_remainder,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
  output logic [CNT_W-1:0]           drop_cnt,
`endif
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [N+M-1:0] mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic           drop;

  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];

  // Wrap bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_idx == rd_idx) &&
                 (wr_ptr[AW] != rd_ptr[AW]);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign push      = result_ready && (!full || pop);
  assign drop      = result_ready && full && !pop;

  assign out_merchant  = mem[rd_idx][N+M-1:M];
  assign out_remainder = mem[rd_idx][M-1:0];
  assign fifo_count    = wr_ptr - rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_idx] <= {merchant, remainder};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A drop in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

`ifdef DIV_RESULT_BUF_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (clr_ovf) begin
        drop_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (drop_cnt != {CNT_W{1'b1}}) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end else if (clr_ovf) begin
      drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_div_result_buffer.sv
// tb_div_result_buffer: randomized and directed checks
// against a queue-based reference model.
module tb_div_result_buffer;

  localparam int N     = 5;
  localparam int M     = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             result_ready;
  logic [N-1:0]     merchant;
  logic [M-1:0]     remainder;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_merchant;
  logic [M-1:0]     out_remainder;
  logic [2:0]       fifo_count;
  logic             overflow;
  logic             clr_ovf;
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
  logic [CNT_W-1:0] drop_cnt;
`endif

  int checks;
  int failures;

  logic [N+M-1:0] q[$];
  bit             m_ovf;
  int             m_drops;

  div_result_buffer #(
    .N(N), .M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .result_ready(result_ready),
    .merchant(merchant),
    .remainder(remainder),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_merchant(out_merchant),
    .out_remainder(out_remainder),
    .fifo_count(fifo_count),
    .overflow(overflow),
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus; the model follows the
  // FIFO rules with a queue and plain counters.
  task automatic cycle(
    input bit           rr,
    input logic [N-1:0] m,
    input logic [M-1:0] r,
    input bit           ordy,
    input bit           clr
  );
    bit was_full;
    bit do_pop;
    result_ready = rr;
    merchant     = m;
    remainder    = r;
    out_ready    = ordy;
    clr_ovf      = clr;
    was_full = (q.size() == DEPTH);
    do_pop   = ordy && (q.size() > 0);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (rr && (!was_full || do_pop)) q.push_back({m, r});
    if (rr && was_full && !do_pop) begin
      m_ovf = 1'b1;
      if (clr) m_drops = 1;
      else if (m_drops < CMAX) m_drops++;
    end else if (clr) begin
      m_ovf   = 1'b0;
      m_drops = 0;
    end
    #1;
    result_ready = 1'b0;
    out_ready    = 1'b0;
    clr_ovf      = 1'b0;
  endtask

  task automatic test_reset();
    cycle(1, 5'd3, 3'd2, 0, 0);
    cycle(1, 5'd7, 3'd1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf   = 1'b0;
    m_drops = 0;
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 ||
        out_merchant !== 5'd0 || out_remainder !== 3'd0 ||
        overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset: v=%b cnt=%0d m=%0d r=%0d ovf=%b want 0",
               out_valid, fifo_count, out_merchant,
               out_remainder, overflow);
    end
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cycle(1, 5'd5, 3'd0, 1, 0);
    checks++;
    if (out_valid !== 1'b1 || out_merchant !== 5'd5 ||
        out_remainder !== 3'd0 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL single_push: v=%b m=%0d r=%0d cnt=%0d want 1/5/0/1",
               out_valid, out_merchant, out_remainder, fifo_count);
    end
    cycle(0, 5'd0, 3'd0, 1, 0);
    checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL single_pop: v=%b cnt=%0d want 0/0",
               out_valid, fifo_count);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++)
      cycle(1, 5'(i), 3'(i % 8), 0, 0);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_state: cnt=%0d ovf=%b want 4/1",
               fifo_count, overflow);
    end
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd2) begin
      failures++;
      $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt);
    end
`endif
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_merchant !== 5'(i) ||
          out_remainder !== 3'(i)) begin
        failures++;
        $display("FAIL ovf_drain%0d: v=%b m=%0d r=%0d want %0d/%0d",
                 i, out_valid, out_merchant, out_remainder, i, i);
      end
      cycle(0, 5'd0, 3'd0, 1, 0);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL ovf_empty: v=%b want 0", out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(10 + i), 3'(i), 0, 0);
    cycle(1, 5'd9, 3'd5, 1, 0);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== m_ovf ||
        out_merchant !== 5'd11) begin
      failures++;
      $display("FAIL full_pp: cnt=%0d ovf=%b head=%0d want 4/%b/11",
               fifo_count, overflow, out_merchant, m_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 ||
          {out_merchant, out_remainder} !== q[0]) begin
        failures++;
        $display("FAIL full_pp_drain%0d: v=%b got %h want %h",
                 i, out_valid, {out_merchant, out_remainder}, q[0]);
      end
      if (i == 3) begin
        checks++;
        if (out_merchant !== 5'd9) begin
          failures++;
          $display("FAIL full_pp_last: got %0d want 9",
                   out_merchant);
        end
      end
      cycle(0, 5'd0, 3'd0, 1, 0);
    end
  endtask

  task automatic test_clear_collision();
    cycle(0, 5'd0, 3'd0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_alone0: ovf=%b want 0", overflow);
    end
    for (int i = 0; i < 4; i++)
      cycle(1, 5'(20 + i), 3'(i), 0, 0);
    cycle(1, 5'd31, 3'd7, 0, 1);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL clr_collide: ovf=%b cnt=%0d want 1/4",
               overflow, fifo_count);
    end
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd1) begin
      failures++;
      $display("FAIL clr_collide_cnt: got %0d want 1", drop_cnt);
    end
`endif
    cycle(0, 5'd0, 3'd0, 0, 1);
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_alone: ovf=%b want 0", overflow);
    end
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 8'd0) begin
      failures++;
      $display("FAIL clr_alone_cnt: got %0d want 0", drop_cnt);
    end
`endif
  endtask

  task automatic test_saturate();
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
    for (int i = 0; i < CMAX + 6; i++)
      cycle(1, 5'(i), 3'(i), 0, 0);
    checks++;
    if (drop_cnt !== 8'(CMAX) || fifo_count !== 3'd4) begin
      failures++;
      $display("FAIL saturate: cnt=%0d occ=%0d want %0d/4",
               drop_cnt, fifo_count, CMAX);
    end
`endif
    while (q.size() > 0) cycle(0, 5'd0, 3'd0, 1, 0);
    cycle(0, 5'd0, 3'd0, 0, 1);
  endtask

  task automatic test_stream();
    int d;
    int exp_d;
    int budget;
    bit ordy;
    d     = 0;
    exp_d = 0;
    ordy  = 1'b0;
    budget = 0;
    while (exp_d < 32 && budget < 200) begin
      budget++;
      if (out_valid && ordy) begin
        checks++;
        if (int'(out_merchant) * 7 + int'(out_remainder) != exp_d) begin
          failures++;
          $display("FAIL stream%0d: got %0d*7+%0d want %0d",
                   exp_d, out_merchant, out_remainder, exp_d);
        end
        exp_d++;
      end
      if (!ordy && d < 32) begin
        cycle(1, 5'(d / 7), 3'(d % 7), ordy, 0);
        d++;
      end else begin
        cycle(0, 5'd0, 3'd0, ordy, 0);
      end
      ordy = !ordy;
    end
    checks++;
    if (exp_d != 32 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL stream_done: popped=%0d ovf=%b want 32/0",
               exp_d, overflow);
    end
  endtask

  task automatic test_random();
    bit rr;
    bit ordy;
    bit clr;
    for (int i = 0; i < 400; i++) begin
      rr   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) == 0);
      clr  = ($urandom_range(0, 15) == 0);
      cycle(rr, 5'($urandom), 3'($urandom), ordy, clr);
      checks++;
      if (out_valid !== (q.size() > 0) ||
          fifo_count !== 3'(q.size()) ||
          overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand%0d: v=%b cnt=%0d ovf=%b want %b/%0d/%b",
                 i, out_valid, fifo_count, overflow,
                 q.size() > 0, q.size(), m_ovf);
      end
      if (q.size() > 0) begin
        checks++;
        if ({out_merchant, out_remainder} !== q[0]) begin
          failures++;
          $display("FAIL rand_head%0d: got %h want %h",
                   i, {out_merchant, out_remainder}, q[0]);
        end
      end
`ifdef DIV_RESULT_BUF_DROP_CNT_EN
      checks++;
      if (drop_cnt !== 8'(m_drops)) begin
        failures++;
        $display("FAIL rand_drop%0d: got %0d want %0d",
                 i, drop_cnt, m_drops);
      end
`endif
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    m_ovf        = 1'b0;
    m_drops      = 0;
    rst_n        = 1'b0;
    result_ready = 1'b0;
    merchant     = '0;
    remainder    = '0;
    out_ready    = 1'b0;
    clr_ovf      = 1'b0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_clear_collision();
    while (q.size() > 0) cycle(0, 5'd0, 3'd0, 1, 0);
    test_saturate();
    test_stream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
